// File: rtl/intersection_ctrl.sv
// N-way traffic-light sequencer: staggered power-up, green/yellow/all-red cycling,
// preferential requests, per-light forced red, green extension and flashing-yellow mode.
module intersection_ctrl #(
  parameter int N_LIGHTS = 4,
  parameter int STAGGER  = 7,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 2,
  parameter int BLINK_T  = 4,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          attention,
  input  logic                          preset,
  input  logic [CNT_W-1:0]              preset_adds,
  input  logic [N_LIGHTS-1:0]           force_reds,
  input  logic [N_LIGHTS-1:0]           preferentials,
  output logic [N_LIGHTS-1:0][2:0]      ltfs,
  output logic                          lgreen,
  output logic [$clog2(N_LIGHTS)-1:0]   cur_idx
);

  localparam int IDX_W = $clog2(N_LIGHTS);
  localparam int TW    = CNT_W + 1;

  localparam logic [2:0] C_OFF = 3'b000;
  localparam logic [2:0] C_RED = 3'b100;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_GRN = 3'b001;

  // Timers count down to zero, so each holds its duration minus one.
  localparam logic [TW-1:0] T_STAG = TW'(STAGGER - 1);
  localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] T_BLK  = TW'(BLINK_T - 1);

  typedef enum logic [2:0] {
    S_OFF, S_STARTUP, S_ALLRED, S_GREEN, S_YELLOW, S_ATTN
  } state_t;

  state_t                     r_state,   w_state;
  logic [TW-1:0]              r_timer,   w_timer;
  logic [IDX_W-1:0]           r_cur_idx, w_cur_idx;
  logic [IDX_W-1:0]           r_lit,     w_lit;
  logic                       r_blink,   w_blink;
  logic [CNT_W-1:0]           r_extra;
  logic [N_LIGHTS-1:0][2:0]   r_ltfs,    w_ltfs;
  logic                       r_lgreen;

  logic                       w_tmr_zero;
  logic [TW-1:0]              w_tmr_dec;
  logic [TW-1:0]              w_green_t;
  logic                       w_found;
  logic [IDX_W-1:0]           w_sel;
  logic [IDX_W-1:0]           w_rr;

  assign w_tmr_zero = (r_timer == '0);
  assign w_tmr_dec  = r_timer - TW'(1);
  assign w_green_t  = TW'(GREEN_T - 1) + {1'b0, r_extra};

  // Next-light selection: round-robin candidate first, preferential request overrides.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_found = 1'b0;
    w_sel   = r_cur_idx;
    w_rr    = r_cur_idx;
    for (int k = N_LIGHTS - 1; k >= 0; k--) begin
      w_rr = IDX_W'((int'(r_cur_idx) + k + 1) % N_LIGHTS);
      if (!force_reds[w_rr]) begin
        w_found = 1'b1;
        w_sel   = w_rr;
      end
    end
    for (int k = N_LIGHTS - 1; k >= 0; k--) begin
      if (preferentials[k] && !force_reds[k]) w_sel = IDX_W'(k);
    end
  end

  always_comb begin
    w_state   = r_state;
    w_timer   = r_timer;
    w_cur_idx = r_cur_idx;
    w_lit     = r_lit;
    w_blink   = r_blink;
    case (r_state)
      S_OFF: begin
        w_state = S_STARTUP;
        w_lit   = '0;
        w_timer = T_STAG;
      end
      S_STARTUP: begin
        if (!w_tmr_zero) begin
          w_timer = w_tmr_dec;
        end else if (r_lit == IDX_W'(N_LIGHTS - 1)) begin
          w_state = S_ALLRED;
          w_timer = T_AR;
        end else begin
          w_lit   = r_lit + IDX_W'(1);
          w_timer = T_STAG;
        end
      end
      S_ALLRED: begin
        if (attention) begin
          w_state = S_ATTN;
          w_blink = 1'b1;
          w_timer = T_BLK;
        end else if (!w_tmr_zero) begin
          w_timer = w_tmr_dec;
        end else if (w_found) begin
          w_state   = S_GREEN;
          w_cur_idx = w_sel;
          w_timer   = w_green_t;
        end else begin
          w_timer = T_AR;
        end
      end
      S_GREEN: begin
        if (attention) begin
          w_state = S_ATTN;
          w_blink = 1'b1;
          w_timer = T_BLK;
        end else if (force_reds[r_cur_idx] || w_tmr_zero) begin
          w_state = S_YELLOW;
          w_timer = T_YEL;
        end else begin
          w_timer = w_tmr_dec;
        end
      end
      S_YELLOW: begin
        if (attention) begin
          w_state = S_ATTN;
          w_blink = 1'b1;
          w_timer = T_BLK;
        end else if (w_tmr_zero) begin
          w_state = S_ALLRED;
          w_timer = T_AR;
        end else begin
          w_timer = w_tmr_dec;
        end
      end
      S_ATTN: begin
        if (!attention) begin
          w_state = S_ALLRED;
          w_timer = T_AR;
        end else if (w_tmr_zero) begin
          w_blink = ~r_blink;
          w_timer = T_BLK;
        end else begin
          w_timer = w_tmr_dec;
        end
      end
      default: w_state = S_OFF;
    endcase
  end

  // Lamp pattern is decoded from the next state so the registered outputs line up with it.
  always_comb begin
    w_ltfs = '0;
    for (int k = 0; k < N_LIGHTS; k++) begin
      case (w_state)
        S_STARTUP: w_ltfs[k] = (k <= int'(w_lit)) ? C_RED : C_OFF;
        S_ALLRED:  w_ltfs[k] = C_RED;
        S_GREEN:   w_ltfs[k] = (IDX_W'(k) == w_cur_idx) ? C_GRN : C_RED;
        S_YELLOW:  w_ltfs[k] = (IDX_W'(k) == w_cur_idx) ? C_YEL : C_RED;
        S_ATTN:    w_ltfs[k] = w_blink ? C_YEL : C_OFF;
        default:   w_ltfs[k] = C_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      // NOTE: no storage arrays here, so every register gets a defined reset value.
      r_state   <= S_OFF;
      r_timer   <= '0;
      r_cur_idx <= IDX_W'(N_LIGHTS - 1);
      r_lit     <= '0;
      r_blink   <= 1'b0;
      r_extra   <= '0;
      r_ltfs    <= '0;
      r_lgreen  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_timer   <= w_timer;
      r_cur_idx <= w_cur_idx;
      r_lit     <= w_lit;
      r_blink   <= w_blink;
      r_ltfs    <= w_ltfs;
      r_lgreen  <= (w_state == S_GREEN);
      if (preset && r_state != S_OFF && r_state != S_STARTUP) r_extra <= preset_adds;
    end
  end

  assign ltfs    = r_ltfs;
  assign lgreen  = r_lgreen;
  assign cur_idx = r_cur_idx;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: stimulus pushes per-cycle expected lamp frames,
// a monitor pops one frame per clock edge and compares it with the outputs.
module tb_intersection_ctrl;

  localparam logic [2:0] DARK = 3'b000;
  localparam logic [2:0] RED  = 3'b100;
  localparam logic [2:0] YEL  = 3'b010;
  localparam logic [2:0] GRN  = 3'b001;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             attention = 1'b0;
  logic             preset = 1'b0;
  logic [7:0]       preset_adds = '0;
  logic [3:0]       force_reds = '0;
  logic [3:0]       preferentials = '0;
  logic [3:0][2:0]  ltfs;
  logic             lgreen;
  logic [1:0]       cur_idx;

  typedef struct {
    string       tag;
    logic [14:0] val;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t sb_e;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intersection_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .attention     (attention),
    .preset        (preset),
    .preset_adds   (preset_adds),
    .force_reds    (force_reds),
    .preferentials (preferentials),
    .ltfs          (ltfs),
    .lgreen        (lgreen),
    .cur_idx       (cur_idx)
  );

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0][2:0] all_l(input logic [2:0] c);
    logic [3:0][2:0] l;
    for (int k = 0; k < 4; k++) l[k] = c;
    return l;
  endfunction

  function automatic logic [3:0][2:0] one_l(input int idx, input logic [2:0] c);
    logic [3:0][2:0] l;
    l = all_l(RED);
    l[idx] = c;
    return l;
  endfunction

  function automatic logic [3:0][2:0] su_l(input int n);
    logic [3:0][2:0] l;
    for (int k = 0; k < 4; k++) l[k] = (k < n) ? RED : DARK;
    return l;
  endfunction

  // Frame layout {ltfs, lgreen, cur_idx}; one entry per upcoming clock edge.
  task automatic sb_run(input string tag, input int n, input logic [3:0][2:0] l,
                        input logic g, input int ci);
    sb_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.val = {l, g, 2'(ci)};
      sb_q.push_back(e);
    end
    repeat (n) @(negedge clk);
  endtask

  task automatic phase(input string tag, input int k, input int glen);
    sb_run({tag, "_g"}, glen, one_l(k, GRN), 1'b1, k);
    sb_run({tag, "_y"}, 3, one_l(k, YEL), 1'b0, k);
    sb_run({tag, "_ar"}, 2, all_l(RED), 1'b0, k);
  endtask

  task automatic startup(input string tag);
    sb_run({tag, "_l0"}, 7, su_l(1), 1'b0, 3);
    sb_run({tag, "_l1"}, 7, su_l(2), 1'b0, 3);
    sb_run({tag, "_l2"}, 7, su_l(3), 1'b0, 3);
    sb_run({tag, "_l3"}, 7, su_l(4), 1'b0, 3);
    sb_run({tag, "_ar"}, 2, all_l(RED), 1'b0, 3);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check(sb_e.tag, {ltfs, lgreen, cur_idx}, sb_e.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb_run("rst", 2, all_l(DARK), 1'b0, 3);
    rst = 1'b1;
    startup("su");

    phase("rr0", 0, 8);
    phase("rr1", 1, 8);
    phase("rr2", 2, 8);
    phase("rr3", 3, 8);

    // Preferential request for light 2 while light 0 is green.
    sb_run("p_g0", 3, one_l(0, GRN), 1'b1, 0);
    preferentials = 4'b0100;
    sb_run("p_g0", 5, one_l(0, GRN), 1'b1, 0);
    sb_run("p_y0", 3, one_l(0, YEL), 1'b0, 0);
    sb_run("p_ar", 2, all_l(RED), 1'b0, 0);
    sb_run("p_g2", 1, one_l(2, GRN), 1'b1, 2);
    preferentials = 4'b0000;
    sb_run("p_g2", 7, one_l(2, GRN), 1'b1, 2);
    sb_run("p_y2", 3, one_l(2, YEL), 1'b0, 2);
    sb_run("p_ar2", 2, all_l(RED), 1'b0, 2);

    // Preset captured mid-green: current green stays 8, the next one lasts 13.
    sb_run("ps_g3", 2, one_l(3, GRN), 1'b1, 3);
    preset = 1'b1;
    preset_adds = 8'd5;
    sb_run("ps_g3", 1, one_l(3, GRN), 1'b1, 3);
    preset = 1'b0;
    preset_adds = 8'd0;
    sb_run("ps_g3", 5, one_l(3, GRN), 1'b1, 3);
    sb_run("ps_y3", 3, one_l(3, YEL), 1'b0, 3);
    sb_run("ps_ar", 2, all_l(RED), 1'b0, 3);

    // Forced red cuts the extended green of light 0 short.
    sb_run("ext_g0", 4, one_l(0, GRN), 1'b1, 0);
    force_reds = 4'b0001;
    sb_run("f_y0", 3, one_l(0, YEL), 1'b0, 0);
    sb_run("f_ar", 2, all_l(RED), 1'b0, 0);
    sb_run("f_g1", 2, one_l(1, GRN), 1'b1, 1);
    force_reds = 4'b0101;
    sb_run("f_g1", 11, one_l(1, GRN), 1'b1, 1);
    sb_run("f_y1", 3, one_l(1, YEL), 1'b0, 1);
    sb_run("f_ar1", 2, all_l(RED), 1'b0, 1);
    phase("skip2", 3, 13);

    // Light 0 skipped again, then everything forced red.
    sb_run("skip0_g1", 2, one_l(1, GRN), 1'b1, 1);
    force_reds = 4'b1111;
    sb_run("all_y1", 3, one_l(1, YEL), 1'b0, 1);
    sb_run("all_red", 12, all_l(RED), 1'b0, 1);

    // Attention mode from the all-forced all-red hold.
    attention = 1'b1;
    sb_run("at_on", 4, all_l(YEL), 1'b0, 1);
    sb_run("at_off", 4, all_l(DARK), 1'b0, 1);
    sb_run("at_on2", 4, all_l(YEL), 1'b0, 1);
    attention = 1'b0;
    force_reds = 4'b0000;
    sb_run("at_ar", 2, all_l(RED), 1'b0, 1);
    sb_run("at_g2", 3, one_l(2, GRN), 1'b1, 2);
    attention = 1'b1;
    sb_run("at_mid", 2, all_l(YEL), 1'b0, 2);

    // Reset in the middle of attention mode; extension must be cleared too.
    rst = 1'b0;
    attention = 1'b0;
    sb_run("rst_mid", 2, all_l(DARK), 1'b0, 3);
    rst = 1'b1;
    startup("su2");
    sb_run("rst_g0", 8, one_l(0, GRN), 1'b1, 0);
    sb_run("rst_y0", 1, one_l(0, YEL), 1'b0, 0);

    check("sb_empty", 15'(sb_q.size()), 15'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
